// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one I-cache request at a time and
// loads the fetch/decode register, with stall, bubble and branch-redirect handling.
module fetch_stage #(
  parameter int VIRT_ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [VIRT_ADDR_WIDTH-1:0] BOOT_ADDR = 32'h0000_1000,
  parameter logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wrt_en,
  input  logic                       branch_taken,
  input  logic [VIRT_ADDR_WIDTH-1:0] branch_target,
  input  logic                       icache_valid,
  input  logic [INST_WIDTH-1:0]      icache_data,
  output logic                       icache_req,
  output logic [VIRT_ADDR_WIDTH-1:0] icache_addr,
  output logic [INST_WIDTH-1:0]      instruction,
  output logic [VIRT_ADDR_WIDTH-1:0] PCNEXT_FETCH,
  output logic                       block_pipe_instr_cache
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

  localparam logic [VIRT_ADDR_WIDTH-1:0] PC_STEP = VIRT_ADDR_WIDTH'(4);

  state_t                       state_q, state_d;
  logic [VIRT_ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [VIRT_ADDR_WIDTH-1:0]   pcnext_q, pcnext_d;
  logic [INST_WIDTH-1:0]        instr_q, instr_d;
  logic [INST_WIDTH-1:0]        hold_q, hold_d;
  logic [VIRT_ADDR_WIDTH-1:0]   pc_inc;
  logic                         ready;

  assign pc_inc = pc_q + PC_STEP;
  assign ready  = ((state_q == S_WAIT) && icache_valid) || (state_q == S_HOLD);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= BOOT_ADDR;
      pcnext_q <= '0;
      instr_q  <= NOP_INST;
      hold_q   <= NOP_INST;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pcnext_q <= pcnext_d;
      instr_q  <= instr_d;
      hold_q   <= hold_d;
    end
  end

  // A redirect squashes the output register and any ready word; an outstanding
  // request must still be drained before the target can be fetched.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pcnext_d = pcnext_q;
    instr_d  = instr_q;
    hold_d   = hold_q;
    if (branch_taken) begin
      pc_d    = {branch_target[VIRT_ADDR_WIDTH-1:2], 2'b00};
      instr_d = NOP_INST;
      case (state_q)
        S_FETCH: state_d = S_DRAIN;
        S_WAIT:  state_d = icache_valid ? S_FETCH : S_DRAIN;
        S_HOLD:  state_d = S_FETCH;
        S_DRAIN: state_d = icache_valid ? S_FETCH : S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end else begin
      if (!ready && wrt_en) begin
        instr_d = NOP_INST;
      end
      case (state_q)
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (icache_valid) begin
            if (wrt_en) begin
              instr_d  = icache_data;
              pcnext_d = pc_inc;
              pc_d     = pc_inc;
              state_d  = S_FETCH;
            end else begin
              hold_d  = icache_data;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (wrt_en) begin
            instr_d  = hold_q;
            pcnext_d = pc_inc;
            pc_d     = pc_inc;
            state_d  = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (icache_valid) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign icache_req             = (state_q == S_FETCH) & reset;
  assign icache_addr            = pc_q;
  assign instruction            = instr_q;
  assign PCNEXT_FETCH           = pcnext_q;
  assign block_pipe_instr_cache = reset & ~ready;

endmodule
